// File: rtl/mopshub_pkg.sv
// -----------------------------------------------------------------------------
// mopshub_pkg
// Shared types and constants for the MOPSHUB bus initialisation sequencer.
//   seq_state_t  : sequencer FSM state encoding
//   MAX_N_BUSES  : largest supported CAN bus count
//   seq_max()    : elaboration-time maximum, used to size the shared timer
// -----------------------------------------------------------------------------
package mopshub_pkg;

    localparam int MAX_N_BUSES = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_POWER,
        ST_TRIM_REQ,
        ST_TRIM_WAIT,
        ST_NEXT,
        ST_DONE
    } seq_state_t;

    function automatic int seq_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mopshub_seq_timer.sv
// -----------------------------------------------------------------------------
// mopshub_seq_timer
// Loadable down-counter with a zero flag. Shared by the settle and the trim
// timeout intervals. Counts down to zero and then holds there.
// Ports:
//   clk        : system clock
//   rst        : asynchronous active-high reset
//   i_load     : load i_load_val this cycle (has priority over counting)
//   i_load_val : value to load
//   o_zero     : counter currently reads zero
// -----------------------------------------------------------------------------
module mopshub_seq_timer #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/mopshub_bus_init_sequencer.sv
// -----------------------------------------------------------------------------
// mopshub_bus_init_sequencer
// Walks the enabled CAN buses in index order: powers each one, waits a settle
// interval, optionally requests oscillator trim (with timeout and retry), and
// finally pulses end_init / sign_on_sig. Buses whose trim never completes are
// reported in fail_mask.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start           : one-cycle pulse, accepted only when idle
//   bus_mask        : per-bus enable, sampled with start
//   osc_auto_trim   : run trim per bus, sampled with start
//   end_trim_bus    : trim-complete pulse (honoured only while waiting)
//   endwait_all     : force the current trim wait to succeed
//   power_bus_en    : power enable for bus power_bus_cnt
//   power_bus_cnt   : current bus index
//   start_trim_ack  : one-cycle trim request
//   start_init      : one-cycle pulse when start is accepted
//   end_init        : one-cycle completion pulse
//   sign_on_sig     : one-cycle pulse coincident with end_init
//   busy            : high whenever not idle
//   fail_mask       : buses that exhausted their trim retries
// -----------------------------------------------------------------------------
module mopshub_bus_init_sequencer
    import mopshub_pkg::*;
#(
    parameter int N_BUSES      = 16,
    parameter int CNT_W        = $clog2(N_BUSES),
    parameter int POWER_SETTLE = 64,
    parameter int TRIM_TIMEOUT = 4096,
    parameter int MAX_RETRY    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_BUSES-1:0] bus_mask,
    input  logic               osc_auto_trim,
    input  logic               end_trim_bus,
    input  logic               endwait_all,
    output logic               power_bus_en,
    output logic [CNT_W-1:0]   power_bus_cnt,
    output logic               start_trim_ack,
    output logic               start_init,
    output logic               end_init,
    output logic               sign_on_sig,
    output logic               busy,
    output logic [N_BUSES-1:0] fail_mask
);

    // The timer is loaded with (interval - 1) so that o_zero marks the last
    // cycle of the interval; the widest interval minus one always fits.
    localparam int                TMR_MAX      = seq_max(POWER_SETTLE, TRIM_TIMEOUT);
    localparam int                TMR_W        = $clog2(TMR_MAX);
    localparam logic [TMR_W-1:0]  SETTLE_LOAD  = TMR_W'(POWER_SETTLE - 1);
    localparam logic [TMR_W-1:0]  TIMEOUT_LOAD = TMR_W'(TRIM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  LAST_IDX     = CNT_W'(N_BUSES - 1);
    localparam logic [2:0]        RETRY_LIMIT  = 3'(MAX_RETRY);

    seq_state_t         r_state;
    logic [N_BUSES-1:0] r_mask;
    logic               r_trim_en;
    logic [2:0]         r_retry;
    logic [CNT_W-1:0]   r_idx;
    logic               r_power_en;
    logic               r_trim_ack;
    logic               r_start_init;
    logic               r_end_init;
    logic               r_sign_on;
    logic               r_busy;
    logic [N_BUSES-1:0] r_fail;

    logic               w_tmr_load;
    logic [TMR_W-1:0]   w_tmr_val;
    logic               w_tmr_zero;
    logic               w_trim_done;
    logic               w_last;

    assign w_trim_done = end_trim_bus | endwait_all;
    assign w_last      = (r_idx == LAST_IDX);

    // Settle is loaded on SCAN->POWER, the timeout on every TRIM_REQ.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = SETTLE_LOAD;
        case (r_state)
            ST_SCAN:     w_tmr_load = r_mask[r_idx];
            ST_TRIM_REQ: begin
                w_tmr_load = 1'b1;
                w_tmr_val  = TIMEOUT_LOAD;
            end
            default:     w_tmr_load = 1'b0;
        endcase
    end

    mopshub_seq_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_zero     (w_tmr_zero)
    );

    // Single FSM; outputs are registered alongside the state so each one is
    // asserted in the same cycle the corresponding state becomes current.
    // NOTE: latched configuration (r_mask, r_trim_en) is reset too; it is a
    // handful of flops, not a memory, so a known value costs nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_mask       <= '0;
            r_trim_en    <= 1'b0;
            r_retry      <= '0;
            r_idx        <= '0;
            r_power_en   <= 1'b0;
            r_trim_ack   <= 1'b0;
            r_start_init <= 1'b0;
            r_end_init   <= 1'b0;
            r_sign_on    <= 1'b0;
            r_busy       <= 1'b0;
            r_fail       <= '0;
        end else begin
            r_trim_ack   <= 1'b0;
            r_start_init <= 1'b0;
            r_end_init   <= 1'b0;
            r_sign_on    <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mask       <= bus_mask;
                        r_trim_en    <= osc_auto_trim;
                        r_fail       <= '0;
                        r_retry      <= '0;
                        r_idx        <= '0;
                        r_start_init <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= ST_SCAN;
                    end
                end

                ST_SCAN: begin
                    if (r_mask[r_idx]) begin
                        r_power_en <= 1'b1;
                        r_state    <= ST_POWER;
                    end else if (w_last) begin
                        r_end_init <= 1'b1;
                        r_sign_on  <= 1'b1;
                        r_state    <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + CNT_W'(1);
                    end
                end

                ST_POWER: begin
                    if (w_tmr_zero) begin
                        if (r_trim_en) begin
                            r_trim_ack <= 1'b1;
                            r_state    <= ST_TRIM_REQ;
                        end else begin
                            r_power_en <= 1'b0;
                            r_state    <= ST_NEXT;
                        end
                    end
                end

                ST_TRIM_REQ: begin
                    r_state <= ST_TRIM_WAIT;
                end

                ST_TRIM_WAIT: begin
                    // Completion wins over a timeout expiring in the same cycle.
                    if (w_trim_done) begin
                        r_power_en <= 1'b0;
                        r_state    <= ST_NEXT;
                    end else if (w_tmr_zero) begin
                        if (r_retry < RETRY_LIMIT) begin
                            r_retry    <= r_retry + 3'd1;
                            r_trim_ack <= 1'b1;
                            r_state    <= ST_TRIM_REQ;
                        end else begin
                            r_fail[r_idx] <= 1'b1;
                            r_power_en    <= 1'b0;
                            r_state       <= ST_NEXT;
                        end
                    end
                end

                ST_NEXT: begin
                    r_retry <= '0;
                    if (w_last) begin
                        r_end_init <= 1'b1;
                        r_sign_on  <= 1'b1;
                        r_state    <= ST_DONE;
                    end else begin
                        r_idx   <= r_idx + CNT_W'(1);
                        r_state <= ST_SCAN;
                    end
                end

                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign power_bus_en   = r_power_en;
    assign power_bus_cnt  = r_idx;
    assign start_trim_ack = r_trim_ack;
    assign start_init     = r_start_init;
    assign end_init       = r_end_init;
    assign sign_on_sig    = r_sign_on;
    assign busy           = r_busy;
    assign fail_mask      = r_fail;

endmodule

// File: tb/tb_mopshub_bus_init_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mopshub_bus_init_sequencer
// Directed scenarios with hand-computed event timelines. Each scenario pushes
// its expected events (kind, absolute cycle, bus index, fail_mask) into a
// queue; a monitor turns DUT output activity into events and compares them in
// order. A responder returns end_trim_bus / endwait_all after a programmed
// delay from each start_trim_ack.
// -----------------------------------------------------------------------------
module tb_mopshub_bus_init_sequencer;

    localparam int N  = 4;
    localparam int PS = 4;
    localparam int TT = 16;
    localparam int MR = 1;
    localparam int CW = 2;

    typedef enum logic [2:0] {EV_INIT, EV_PON, EV_POFF, EV_TRIM, EV_DONE} ev_kind_t;

    typedef struct packed {
        ev_kind_t    kind;
        int unsigned cyc;
        logic [7:0]  idx;
        logic [3:0]  fmask;
    } ev_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic [N-1:0]  bus_mask;
    logic          osc_auto_trim;
    logic          stim_end_trim;
    logic          resp_end_trim;
    logic          resp_endwait;
    logic          end_trim_bus;
    logic          endwait_all;
    logic          power_bus_en;
    logic [CW-1:0] power_bus_cnt;
    logic          start_trim_ack;
    logic          start_init;
    logic          end_init;
    logic          sign_on_sig;
    logic          busy;
    logic [N-1:0]  fail_mask;

    assign end_trim_bus = stim_end_trim | resp_end_trim;
    assign endwait_all  = resp_endwait;

    int unsigned cyc;
    int          n_checks;
    int          n_fail;
    int          trim_dly;
    int          ew_dly;
    ev_t         sb_q[$];

    mopshub_bus_init_sequencer #(
        .N_BUSES      (N),
        .CNT_W        (CW),
        .POWER_SETTLE (PS),
        .TRIM_TIMEOUT (TT),
        .MAX_RETRY    (MR)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .bus_mask       (bus_mask),
        .osc_auto_trim  (osc_auto_trim),
        .end_trim_bus   (end_trim_bus),
        .endwait_all    (endwait_all),
        .power_bus_en   (power_bus_en),
        .power_bus_cnt  (power_bus_cnt),
        .start_trim_ack (start_trim_ack),
        .start_init     (start_init),
        .end_init       (end_init),
        .sign_on_sig    (sign_on_sig),
        .busy           (busy),
        .fail_mask      (fail_mask)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle number: value seen at a negedge names the cycle just started.
    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic ev_t mk_ev(ev_kind_t k, int unsigned c, int i, logic [3:0] f);
        ev_t e;
        e.kind  = k;
        e.cyc   = c;
        e.idx   = 8'(i);
        e.fmask = f;
        return e;
    endfunction

    task automatic expect_ev(ev_kind_t k, int unsigned c, int i, logic [3:0] f);
        sb_q.push_back(mk_ev(k, c, i, f));
    endtask

    task automatic observe(ev_kind_t k);
        ev_t act;
        ev_t exp;
        act = mk_ev(k, cyc, int'(power_bus_cnt), fail_mask);
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got %s at cycle %0d idx=%0d fail_mask=%b, none expected",
                     k.name(), act.cyc, act.idx, act.fmask);
        end else begin
            exp = sb_q.pop_front();
            if (act !== exp) begin
                n_fail++;
                $display("FAIL event_%s: got %s@%0d idx=%0d fm=%b, expected %s@%0d idx=%0d fm=%b",
                         exp.kind.name(), act.kind.name(), act.cyc, act.idx, act.fmask,
                         exp.kind.name(), exp.cyc, exp.idx, exp.fmask);
            end
        end
    endtask

    // Monitor: converts output pulses and power_bus_en edges into events.
    initial begin
        logic prev_pen;
        prev_pen = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_pen = 1'b0;
            end else begin
                if (start_init)                  observe(EV_INIT);
                if (power_bus_en && !prev_pen)   observe(EV_PON);
                if (!power_bus_en && prev_pen)   observe(EV_POFF);
                if (start_trim_ack)              observe(EV_TRIM);
                if (end_init) begin
                    observe(EV_DONE);
                    check("sign_on_with_end_init", 32'(sign_on_sig), 32'd1);
                    check("busy_in_done", 32'(busy), 32'd1);
                end
                if (sign_on_sig) check("end_init_with_sign_on", 32'(end_init), 32'd1);
                prev_pen = power_bus_en;
            end
        end
    end

    // Trim responder: pulses end_trim_bus / endwait_all a set number of cycles
    // after each start_trim_ack (0 = never).
    initial begin
        int wcnt;
        bit armed;
        resp_end_trim = 1'b0;
        resp_endwait  = 1'b0;
        armed = 1'b0;
        wcnt  = 0;
        forever begin
            @(negedge clk);
            resp_end_trim = 1'b0;
            resp_endwait  = 1'b0;
            if (rst) begin
                armed = 1'b0;
            end else begin
                if (armed) begin
                    wcnt++;
                    if (trim_dly > 0 && wcnt == trim_dly) resp_end_trim = 1'b1;
                    if (ew_dly > 0 && wcnt == ew_dly)     resp_endwait  = 1'b1;
                    if (wcnt >= trim_dly && wcnt >= ew_dly) armed = 1'b0;
                end
                if (start_trim_ack && (trim_dly > 0 || ew_dly > 0)) begin
                    armed = 1'b1;
                    wcnt  = 0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before the end of the run");
        $fatal(1, "watchdog expired");
    end

    task automatic check_all_zero(input string pfx);
        check({pfx, "_power_bus_en"},   32'(power_bus_en),   32'd0);
        check({pfx, "_power_bus_cnt"},  32'(power_bus_cnt),  32'd0);
        check({pfx, "_start_trim_ack"}, 32'(start_trim_ack), 32'd0);
        check({pfx, "_start_init"},     32'(start_init),     32'd0);
        check({pfx, "_end_init"},       32'(end_init),       32'd0);
        check({pfx, "_sign_on_sig"},    32'(sign_on_sig),    32'd0);
        check({pfx, "_busy"},           32'(busy),           32'd0);
        check({pfx, "_fail_mask"},      32'(fail_mask),      32'd0);
    endtask

    // Sets up inputs at a negedge; s is the cycle in which start_init must show.
    task automatic arm_start(input logic [N-1:0] m, input logic t, output int unsigned s);
        @(negedge clk);
        bus_mask      = m;
        osc_auto_trim = t;
        s             = cyc + 1;
    endtask

    task automatic fire_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_until(input int unsigned c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while ((sb_q.size() != 0 || busy) && k < 400) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        check({name, "_pending_events"}, 32'(sb_q.size()), 32'd0);
        check({name, "_idle_busy"},      32'(busy),         32'd0);
        check({name, "_idle_power"},     32'(power_bus_en), 32'd0);
    endtask

    initial begin
        int unsigned s;
        n_checks      = 0;
        n_fail        = 0;
        trim_dly      = 0;
        ew_dly        = 0;
        rst           = 1'b0;
        start         = 1'b0;
        bus_mask      = '0;
        osc_auto_trim = 1'b0;
        stim_end_trim = 1'b0;

        #1 rst = 1'b1;
        #2 check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("after_reset");

        // 1: all buses, no trim. 6 cycles per bus, DONE 24 after start_init.
        arm_start(4'b1111, 1'b0, s);
        expect_ev(EV_INIT, s, 0, 4'b0);
        for (int b = 0; b < N; b++) begin
            expect_ev(EV_PON,  s + 6*b + 1, b, 4'b0);
            expect_ev(EV_POFF, s + 6*b + 5, b, 4'b0);
        end
        expect_ev(EV_DONE, s + 24, 3, 4'b0);
        fire_start();
        wait_done("t1");

        // 2: buses 1 and 3 with trim, completion 5 cycles after each request.
        // A stray end_trim_bus during POWER must be ignored.
        trim_dly = 5;
        arm_start(4'b1010, 1'b1, s);
        expect_ev(EV_INIT, s,      0, 4'b0);
        expect_ev(EV_PON,  s + 2,  1, 4'b0);
        expect_ev(EV_TRIM, s + 6,  1, 4'b0);
        expect_ev(EV_POFF, s + 12, 1, 4'b0);
        expect_ev(EV_PON,  s + 15, 3, 4'b0);
        expect_ev(EV_TRIM, s + 19, 3, 4'b0);
        expect_ev(EV_POFF, s + 25, 3, 4'b0);
        expect_ev(EV_DONE, s + 26, 3, 4'b0);
        fire_start();
        wait_until(s + 3);
        stim_end_trim = 1'b1;
        @(negedge clk);
        stim_end_trim = 1'b0;
        wait_done("t2");
        trim_dly = 0;

        // 3: bus 0 trim never completes: two requests 17 apart, then failure.
        arm_start(4'b0001, 1'b1, s);
        expect_ev(EV_INIT, s,      0, 4'b0);
        expect_ev(EV_PON,  s + 1,  0, 4'b0);
        expect_ev(EV_TRIM, s + 5,  0, 4'b0);
        expect_ev(EV_TRIM, s + 22, 0, 4'b0);
        expect_ev(EV_POFF, s + 39, 0, 4'b0001);
        expect_ev(EV_DONE, s + 43, 3, 4'b0001);
        fire_start();
        wait_done("t3");
        check("t3_fail_mask_held", 32'(fail_mask), 32'h1);

        // 4: bus 2, endwait_all 3 cycles after the request; fail_mask cleared.
        ew_dly = 3;
        arm_start(4'b0100, 1'b1, s);
        expect_ev(EV_INIT, s,      0, 4'b0);
        expect_ev(EV_PON,  s + 3,  2, 4'b0);
        expect_ev(EV_TRIM, s + 7,  2, 4'b0);
        expect_ev(EV_POFF, s + 11, 2, 4'b0);
        expect_ev(EV_DONE, s + 13, 3, 4'b0);
        fire_start();
        wait_done("t4");
        ew_dly = 0;

        // 5: completion in the very cycle the timeout expires is a success.
        trim_dly = TT;
        arm_start(4'b0001, 1'b1, s);
        expect_ev(EV_INIT, s,      0, 4'b0);
        expect_ev(EV_PON,  s + 1,  0, 4'b0);
        expect_ev(EV_TRIM, s + 5,  0, 4'b0);
        expect_ev(EV_POFF, s + 22, 0, 4'b0);
        expect_ev(EV_DONE, s + 26, 3, 4'b0);
        fire_start();
        wait_done("t5_timeout_edge");

        // 6: end_trim_bus and endwait_all together count once.
        trim_dly = 2;
        ew_dly   = 2;
        arm_start(4'b0010, 1'b1, s);
        expect_ev(EV_INIT, s,      0, 4'b0);
        expect_ev(EV_PON,  s + 2,  1, 4'b0);
        expect_ev(EV_TRIM, s + 6,  1, 4'b0);
        expect_ev(EV_POFF, s + 9,  1, 4'b0);
        expect_ev(EV_DONE, s + 12, 3, 4'b0);
        fire_start();
        wait_done("t6_both");
        trim_dly = 0;
        ew_dly   = 0;

        // 7: reset during POWER of bus 1 aborts with no completion.
        arm_start(4'b1111, 1'b0, s);
        expect_ev(EV_INIT, s,     0, 4'b0);
        expect_ev(EV_PON,  s + 1, 0, 4'b0);
        expect_ev(EV_POFF, s + 5, 0, 4'b0);
        expect_ev(EV_PON,  s + 7, 1, 4'b0);
        fire_start();
        wait_until(s + 8);
        #2 rst = 1'b1;
        #1 check_all_zero("mid_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("t7_events_before_reset", 32'(sb_q.size()), 32'd0);
        repeat (4) @(negedge clk);
        check_all_zero("after_abort");

        // Restart after the abort begins again at bus 0.
        arm_start(4'b0011, 1'b0, s);
        expect_ev(EV_INIT, s,      0, 4'b0);
        expect_ev(EV_PON,  s + 1,  0, 4'b0);
        expect_ev(EV_POFF, s + 5,  0, 4'b0);
        expect_ev(EV_PON,  s + 7,  1, 4'b0);
        expect_ev(EV_POFF, s + 11, 1, 4'b0);
        expect_ev(EV_DONE, s + 14, 3, 4'b0);
        fire_start();
        wait_done("t7_restart");

        // 8: empty mask: N SCAN cycles then DONE, second start ignored.
        arm_start(4'b0000, 1'b1, s);
        expect_ev(EV_INIT, s,     0, 4'b0);
        expect_ev(EV_DONE, s + 4, 3, 4'b0);
        fire_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t8_empty");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
